// File: rtl/wb_pwm_led_pkg.sv
// wb_pwm_led_pkg: register offsets, CTRL bit positions and the byte-lane
// merge helper shared by the Wishbone PWM LED block.
package wb_pwm_led_pkg;

    // Register offsets, decoded from wb_adr_i[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_PRESC  = 3'd1;
    localparam logic [2:0] REG_DUTY   = 3'd2;
    localparam logic [2:0] REG_BLINK  = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;

    // CTRL bit positions
    localparam int CTRL_EN       = 0;
    localparam int CTRL_BLINK_EN = 1;
    localparam int CTRL_IRQ_EN   = 2;

    // Replace only the bytes whose select bit is set
    function automatic logic [31:0] sel_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
        logic [31:0] m;
        m = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return m;
    endfunction

endpackage

// File: rtl/wb_pwm_led_core.sv
// pwm_led_core: prescaler, 8-bit PWM counter, shadowed duty compare and the
// optional blink gate (built only when PWM_LED_BLINK_EN is defined).
// No bus knowledge; the register file lives in wb_pwm_led.
module pwm_led_core
    import wb_pwm_led_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16,
    parameter int BLINK_W = 16
) (
    input  logic                 clk_s,
    input  logic                 rst,
`ifdef PWM_LED_BLINK_EN
    input  logic                 i_blink_en,
    input  logic [BLINK_W-1:0]   i_blink,
`endif
    input  logic                 i_en,
    input  logic [PRESC_W-1:0]   i_presc,
    input  logic [N_CH*8-1:0]    i_duty,
    output logic [N_CH-1:0]      o_pwm,
    output logic                 o_wrap
);

    logic [PRESC_W-1:0] r_psc;
    logic [7:0]         r_cnt;
    logic [N_CH*8-1:0]  r_duty_act;
    logic               w_tick;
    logic               w_wrap;
    logic               w_gate;

    // >= lets a PRESC write below the running count wrap immediately
    assign w_tick = i_en && (r_psc >= i_presc);
    assign w_wrap = w_tick && (r_cnt == 8'hFF);
    assign o_wrap = w_wrap;

    // Prescaler: count 0..PRESC, held at 0 while disabled
    always_ff @(posedge clk_s) begin
        if (!rst || !i_en || w_tick) r_psc <= '0;
        else                         r_psc <= r_psc + PRESC_W'(1);
    end

    // PWM counter: advance on each tick, natural 255->0 wrap
    always_ff @(posedge clk_s) begin
        if (!rst || !i_en) r_cnt <= 8'd0;
        else if (w_tick)   r_cnt <= r_cnt + 8'd1;
    end

    // Active duty follows the shadow only at a period boundary (or when idle) so no pulse is cut short
    always_ff @(posedge clk_s) begin
        if (!rst)                  r_duty_act <= '0;
        else if (!i_en || w_wrap)  r_duty_act <= i_duty;
    end

`ifdef PWM_LED_BLINK_EN
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_phase;

    // Count wrap events; on reaching BLINK restart and flip the blink phase
    always_ff @(posedge clk_s) begin
        if (!rst) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b0;
        end else if (!i_blink_en) begin
            r_blink_cnt <= '0;
            r_phase     <= 1'b1;
        end else if (w_wrap) begin
            if (r_blink_cnt >= i_blink) begin
                r_blink_cnt <= '0;
                r_phase     <= ~r_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BLINK_W'(1);
            end
        end
    end

    assign w_gate = ~i_blink_en | r_phase;
`else
    assign w_gate = 1'b1;
`endif

    // Per-channel compare against the active duty byte
    always_comb begin
        o_pwm = '0;
        for (int i = 0; i < N_CH; i++) begin
            o_pwm[i] = i_en & w_gate & (r_cnt < r_duty_act[i*8 +: 8]);
        end
    end

endmodule

// File: rtl/wb_pwm_led.sv
// wb_pwm_led: Wishbone slave (GPIO window) with N_CH 8-bit PWM LED outputs,
// a period-wrap status flag and level interrupt. Optional blink gate is
// enabled by defining PWM_LED_BLINK_EN.
module wb_pwm_led
    import wb_pwm_led_pkg::*;
#(
    parameter int N_CH    = 4,
    parameter int PRESC_W = 16,
    parameter int BLINK_W = 16
) (
    input  logic             clk_s,
    input  logic             rst,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_stb_i,
    input  logic             wb_cyc_i,
    output logic             wb_ack_o,
    output logic [N_CH-1:0]  pwm_o,
    output logic             intr
);

    if (N_CH < 1 || N_CH > 4 || PRESC_W < 1 || PRESC_W > 32 ||
        BLINK_W < 1 || BLINK_W > 32) begin : g_bad_param
        $error("wb_pwm_led: parameter out of range");
    end

    // Duty bytes for absent channels are never stored, so they read back 0
    localparam logic [31:0] DUTY_MASK = (N_CH >= 4) ? 32'hFFFF_FFFF
                                                    : ((32'd1 << (8*N_CH)) - 32'd1);

    logic               r_ack;
    logic [31:0]        r_dat;
    logic [2:0]         r_ctrl;
    logic [PRESC_W-1:0] r_presc;
    logic [31:0]        r_duty;
    logic               r_flag;
    logic               w_acc;
    logic               w_wr;
    logic               w_rd;
    logic [2:0]         w_reg;
    logic [31:0]        w_rdata;
    logic               w_wrap;
    logic               w_unused_adr;

    // A new access is accepted only while not acking, giving one ack per two cycles
    assign w_acc        = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr         = w_acc & wb_we_i;
    assign w_rd         = w_acc & ~wb_we_i;
    assign w_reg        = wb_adr_i[4:2];
    assign w_unused_adr = ^{wb_adr_i[31:5], wb_adr_i[1:0]};

`ifdef PWM_LED_BLINK_EN
    logic [BLINK_W-1:0] r_blink;
`endif

    // Read mux
    always_comb begin
        w_rdata = 32'd0;
        case (w_reg)
            REG_CTRL:   w_rdata = {29'd0, r_ctrl};
            REG_PRESC:  w_rdata = 32'(r_presc);
            REG_DUTY:   w_rdata = r_duty;
`ifdef PWM_LED_BLINK_EN
            REG_BLINK:  w_rdata = 32'(r_blink);
`endif
            REG_STATUS: w_rdata = {31'd0, r_flag};
            default:    w_rdata = 32'd0;
        endcase
    end

    // Ack and registered read data; a reset drops any pending ack
    always_ff @(posedge clk_s) begin
        if (!rst) begin
            r_ack <= 1'b0;
            r_dat <= 32'd0;
        end else begin
            r_ack <= w_acc;
            r_dat <= w_rd ? w_rdata : 32'd0;
        end
    end

    // Register writes land on the same edge that raises ack
    always_ff @(posedge clk_s) begin
        if (!rst) begin
            r_ctrl  <= 3'd0;
            r_presc <= '0;
            r_duty  <= 32'd0;
`ifdef PWM_LED_BLINK_EN
            r_blink <= '0;
`endif
        end else if (w_wr) begin
            case (w_reg)
                REG_CTRL: if (wb_sel_i[0]) begin
                    r_ctrl[CTRL_EN]       <= wb_dat_i[CTRL_EN];
                    r_ctrl[CTRL_IRQ_EN]   <= wb_dat_i[CTRL_IRQ_EN];
`ifdef PWM_LED_BLINK_EN
                    r_ctrl[CTRL_BLINK_EN] <= wb_dat_i[CTRL_BLINK_EN];
`endif
                end
                REG_PRESC: r_presc <= PRESC_W'(sel_merge(32'(r_presc), wb_dat_i, wb_sel_i));
                REG_DUTY:  r_duty  <= sel_merge(r_duty, wb_dat_i, wb_sel_i) & DUTY_MASK;
`ifdef PWM_LED_BLINK_EN
                REG_BLINK: r_blink <= BLINK_W'(sel_merge(32'(r_blink), wb_dat_i, wb_sel_i));
`endif
                default: ;
            endcase
        end
    end

    // Wrap flag: a wrap on the same edge as a write-1-to-clear keeps it set
    always_ff @(posedge clk_s) begin
        if (!rst)
            r_flag <= 1'b0;
        else if (w_wrap)
            r_flag <= 1'b1;
        else if (w_wr && (w_reg == REG_STATUS) && wb_sel_i[0] && wb_dat_i[0])
            r_flag <= 1'b0;
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat;
    assign intr     = r_flag & r_ctrl[CTRL_IRQ_EN];

    pwm_led_core #(
        .N_CH    (N_CH),
        .PRESC_W (PRESC_W),
        .BLINK_W (BLINK_W)
    ) u_core (
        .clk_s      (clk_s),
        .rst        (rst),
`ifdef PWM_LED_BLINK_EN
        .i_blink_en (r_ctrl[CTRL_BLINK_EN]),
        .i_blink    (r_blink),
`endif
        .i_en       (r_ctrl[CTRL_EN]),
        .i_presc    (r_presc),
        .i_duty     (r_duty[N_CH*8-1:0]),
        .o_pwm      (pwm_o),
        .o_wrap     (w_wrap)
    );

endmodule
